// File: rtl/press_display_pkg.sv
// rtl/press_display_pkg.sv - shared types, segment codes and defaults for the press counter display
package press_display_pkg;

    typedef logic [3:0] bcd_t;

    localparam int DEF_REFRESH_DIV = 100000;
    localparam int DEF_SYNC_STAGES = 2;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_encode(input bcd_t digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low 7-segment decoder with blank override
module bcd_to_seg7
    import press_display_pkg::*;
(
    input  bcd_t       i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = i_blank ? SEG_BLANK : seg7_encode(i_digit);
    end

endmodule

// File: rtl/press_count_display.sv
// rtl/press_count_display.sv - BCD press counter with multiplexed 7-seg scan; LEADING_ZERO_BLANK_EN blanks leading zeros
module press_count_display
    import press_display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  press_i,
    input  logic                  clr_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  ovf_o,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_inc;
    logic [4*DIGITS-1:0]    r_count;
    logic                   r_ovf;
    logic [4*DIGITS-1:0]    w_count_next;
    logic                   w_carry;
    logic [REF_W-1:0]       r_refresh;
    logic [IDX_W-1:0]       r_idx;
    logic [DIGITS-1:0]      r_an;
    logic [6:0]             r_seg;
    logic [DIGITS-1:0]      w_an_next;
    bcd_t                   w_digit;
    logic                   w_blank;
    logic [6:0]             w_seg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], press_i};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_inc = r_sync[SYNC_STAGES-1] & ~r_sync_d;

    // Carry ripples upward only through digits sitting at 9; carry-out is the wrap.
    always_comb begin
        w_carry      = w_inc;
        w_count_next = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_next[4*i +: 4] = 4'd0;
                end else begin
                    w_count_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_inc) begin
            r_count <= w_count_next;
            if (w_carry) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == REF_LAST) begin
            r_refresh <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_upper_zero;
    logic              w_zero_run;

    always_comb begin
        w_upper_zero = '0;
        w_zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run      = w_zero_run & (r_count[4*i +: 4] == 4'd0);
            w_upper_zero[i] = w_zero_run;
        end
    end
`endif

    always_comb begin
        w_digit   = '0;
        w_an_next = '1;
        w_blank   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit      = r_count[4*i +: 4];
                w_an_next[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank      = (i > 0) && w_upper_zero[i];
`endif
            end
        end
    end

    bcd_to_seg7 u_dec (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    // Anode and segment registers share one edge so a digit switch never ghosts.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg;
        end
    end

    assign count_o = r_count;
    assign ovf_o   = r_ovf;
    assign an_o    = r_an;
    assign seg_o   = r_seg;
    assign dp_o    = 1'b1;

endmodule

// File: tb/tb_press_count_display.sv
// tb/tb_press_count_display.sv - scoreboard bench for press_count_display
module tb_press_count_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        press = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] count;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic        press2 = 1'b0;
    logic        clr2 = 1'b0;
    logic [7:0]  count2;
    logic        ovf2;
    logic [1:0]  an2;
    logic [6:0]  seg2;
    logic        dp2;

    press_count_display #(.DIGITS(4), .REFRESH_DIV(4), .SYNC_STAGES(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .press_i(press), .clr_i(clr),
        .count_o(count), .ovf_o(ovf), .an_o(an), .seg_o(seg), .dp_o(dp)
    );

    press_count_display #(.DIGITS(2), .REFRESH_DIV(2), .SYNC_STAGES(3)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .press_i(press2), .clr_i(clr2),
        .count_o(count2), .ovf_o(ovf2), .an_o(an2), .seg_o(seg2), .dp_o(dp2)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [16:0] exp_q[$];
    logic [16:0] prev = 17'h0;
    logic [16:0] mon_cur;
    logic [3:0]  e_an[4];
    logic [6:0]  e_seg[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    // Monitor: every change of {ovf,count} must match the next queued expectation.
    always @(negedge clk) begin
        mon_cur = {ovf, count};
        if (mon_cur !== prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL count_unexpected: got %h expected no change from %h", mon_cur, prev);
            end else begin
                check("count_seq", 32'(mon_cur), 32'(exp_q.pop_front()));
            end
            prev = mon_cur;
        end
    end

    task automatic press_main();
        press = 1'b1;
        repeat (4) @(negedge clk);
        press = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_dut2();
        press2 = 1'b1;
        repeat (5) @(negedge clk);
        press2 = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        for (int k = 0; k < 64 && an !== target; k++) @(negedge clk);
        check(name, 32'(an), 32'(target));
    endtask

    initial begin
        e_an[0] = 4'b1110; e_an[1] = 4'b1101; e_an[2] = 4'b1011; e_an[3] = 4'b0111;
        e_seg[0] = 7'h12;  e_seg[1] = 7'h40;  e_seg[2] = 7'h30;
`ifdef LEADING_ZERO_BLANK_EN
        e_seg[3] = 7'h7F;
`else
        e_seg[3] = 7'h40;
`endif

        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_an", 32'(an), 32'hE);
        check("first_seg", 32'(seg), 32'h40);
        @(negedge clk);

        exp_q.push_back({1'b0, 16'h0001});
        press = 1'b1;
        @(posedge clk); #1;
        check("lat_edge_n", 32'(count), 32'h0);
        @(posedge clk); #1;
        check("lat_edge_n1", 32'(count), 32'h0);
        @(posedge clk); #1;
        check("lat_edge_n2", 32'(count), 32'h0001);
        @(negedge clk);
        repeat (47) @(negedge clk);
        press = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_single", 32'(count), 32'h0001);

        for (int n = 2; n <= 10; n++) begin
            exp_q.push_back({1'b0, to_bcd(n)});
            press_main();
        end
        check("carry_0010", 32'(count), 32'h0010);

        exp_q.push_back(17'h0);
        press = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        repeat (2) @(negedge clk);
        press = 1'b0;
        repeat (6) @(negedge clk);
        check("clr_wins_count", 32'(count), 32'h0);
        check("clr_wins_ovf", 32'(ovf), 32'h0);

        for (int n = 1; n <= 305; n++) begin
            exp_q.push_back({1'b0, to_bcd(n)});
            press_main();
        end
        check("count_0305", 32'(count), 32'h0305);
        wait_an(4'b0111, "scan_sync_a");
        wait_an(4'b1110, "scan_sync_b");
        for (int k = 0; k < 16; k++) begin
            check("scan_an", 32'(an), 32'(e_an[k / 4]));
            check("scan_seg", 32'(seg), 32'(e_seg[k / 4]));
            @(negedge clk);
        end

        exp_q.push_back(17'h0);
        clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        for (int n = 1; n <= 42; n++) begin
            exp_q.push_back({1'b0, to_bcd(n)});
            press_main();
        end
        wait_an(4'b1011, "prerst_sync");
        exp_q.push_back(17'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_ovf", 32'(ovf), 32'h0);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dp", 32'(dp), 32'h1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_an", 32'(an), 32'hE);
        check("restart_seg", 32'(seg), 32'h40);
        repeat (3) @(posedge clk);
        #1;
        check("restart_hold", 32'(an), 32'hE);
        @(posedge clk); #1;
        check("restart_next", 32'(an), 32'hD);
        @(negedge clk);

        for (int n = 1; n <= 99; n++) press_dut2();
        check("d2_count_99", 32'(count2), 32'h99);
        check("d2_ovf_pre", 32'(ovf2), 32'h0);
        press_dut2();
        check("d2_wrap_count", 32'(count2), 32'h00);
        check("d2_wrap_ovf", 32'(ovf2), 32'h1);
        press_dut2();
        check("d2_after_count", 32'(count2), 32'h01);
        check("d2_after_ovf", 32'(ovf2), 32'h1);
        clr2 = 1'b1;
        @(negedge clk) clr2 = 1'b0;
        @(negedge clk);
        check("d2_clr_count", 32'(count2), 32'h00);
        check("d2_clr_ovf", 32'(ovf2), 32'h0);

        repeat (5) @(negedge clk);
        check("main_ovf_idle", 32'(ovf), 32'h0);
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
